mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage pipeline.
- Serialises requests from the two stages, one outstanding memory access at a time.
- Drives the memory handshake and returns read data plus a one-cycle ready pulse to each stage.
- The pipeline stall logic stalls any stage whose request is pending without ready.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- STARVE_MAX, 4, consecutive DM grants tolerated while IF waits (used only with the optional feature)

Ports:
- clock  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_ready
- if_addr  in  AW  fetch address; stable while if_req=1
- if_rdata  out  DW  fetched word; valid in the if_ready cycle, held until the next IF completion
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  data request; level, held until dm_ready
- dm_we  in  1  1=write, 0=read; stable while dm_req=1
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read word; valid in the dm_ready cycle of a read, held otherwise
- dm_ready  out  1  one-cycle completion pulse for DM
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  registered access address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  memory read data, valid with mem_valid
- mem_valid  in  1  completion from memory, for both reads and writes; arrives 1 or more cycles after mem_en
- owner  out  2  current grant: 00 none, 01 IF, 10 DM

Behaviour:
- Clocking and reset: single clock, clock; reset rst is synchronous and active-high.
- Reset values: state=IDLE; mem_en, mem_we, if_ready, dm_ready=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; owner=00; starvation counter=0.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples if_req and dm_req.
  - If either is set, latches the winner's address, write data and we into the mem_* registers.
  - Sets owner and moves to ISSUE.
  - If neither is set, stays in IDLE.
- Arbitration (no macro): DM has strict priority over IF, because DM holds the older instruction.
- ISSUE:
  - mem_en=1 for exactly this cycle.
  - mem_we=dm_we if DM owns the grant, else 0.
  - Unconditionally moves to WAIT.
- WAIT:
  - Stays until mem_valid=1.
  - On mem_valid, captures mem_rdata into the owner's rdata register. A DM write does not update dm_rdata.
  - Moves to DONE.
- DONE:
  - Asserts the owner's ready for one cycle; the other ready stays 0.
  - owner stays valid during DONE, returns to 00 in the following IDLE.
  - Moves to IDLE.
- Latency: with a 1-cycle memory, req sampled in cycle t gives ready in cycle t+3. Each extra memory cycle adds one cycle. Throughput is one access per 4 cycles minimum.
- Requester rule: a requester sees ready and may drop or change req at the next edge. A req still high in IDLE is a new request.
- mem_valid outside WAIT is ignored and causes no state change.
- Reset mid-operation:
  - Returns to IDLE next edge with no ready pulse.
  - A late mem_valid from the aborted access is ignored.
- Widths: no arithmetic on data; addresses pass through unmodified. The starvation counter is clog2(STARVE_MAX+1) bits, saturating.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - The counter increments on each DM grant made while if_req=1, and clears on every IF grant.
  - When the counter equals STARVE_MAX and both requests are pending in IDLE, IF wins. The counter then clears.
- Undefined: counter logic absent; strict DM priority; IF may starve indefinitely.

Test Plan:
- Reset mid-WAIT: rst=1 for 1 cycle during WAIT -> state IDLE, no ready pulse; mem_valid 2 cycles later ignored; all outputs 0.
- IF read, 1-cycle memory:
  - Stimulus: if_req=1, if_addr=0x40; memory returns 0x2002000A.
  - Response: mem_en pulses 1 cycle after req with mem_addr=0x40, mem_we=0; if_ready=1 and if_rdata=0x2002000A exactly 3 cycles after req sampled; owner=01 during the transaction.
- DM write, 3-cycle memory:
  - Stimulus: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF.
  - Response: mem_en=1, mem_we=1 with those values; dm_ready 5 cycles after req; dm_rdata unchanged; if_ready=0.
- Simultaneous requests: if_req=dm_req=1 in the same IDLE cycle -> DM served first (owner=10); IF served in the next transaction; no ready overlap.
- Stray mem_valid: pulse mem_valid while in IDLE with no req -> no ready, no state change.
- Starvation (macro defined, STARVE_MAX=4): if_req held while dm_req re-requests every IDLE -> 4 DM completions, then IF granted on the 5th arbitration. Without the macro, IF is never granted while DM keeps requesting.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF and DM pipeline stages.
// Optional IF starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

  state_t state;
  state_t state_nxt;
  logic   we_r;
  logic   if_wins;
  logic   grant_if;
  logic   grant_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  // IF overrides DM once DM has been granted STARVE_MAX times in a row over a waiting IF.
  assign if_wins = if_req && (!dm_req || (starve_cnt == CW'(STARVE_MAX)));

  always_ff @(posedge clock) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && if_req && (starve_cnt != CW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  // DM holds the older instruction, so it always wins a tie.
  assign if_wins = if_req && !dm_req;
`endif

  assign grant_if = (state == IDLE) && if_wins;
  assign grant_dm = (state == IDLE) && dm_req && !if_wins;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if || grant_dm) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      we_r      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dm) begin
        owner     <= OWN_DM;
        we_r      <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if) begin
        owner    <= OWN_IF;
        we_r     <= 1'b0;
        mem_addr <= if_addr;
      end
      if ((state == WAIT) && mem_valid) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else if (!we_r) begin
          dm_rdata <= mem_rdata;
        end
      end
      if (state == DONE) begin
        owner <= OWN_NONE;
      end
    end
  end

  assign mem_en   = (state == ISSUE);
  assign mem_we   = (state == ISSUE) && we_r;
  assign if_ready = (state == DONE) && (owner == OWN_IF);
  assign dm_ready = (state == DONE) && (owner == OWN_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, IF/DM transactions, tie-break,
// stray completions, reset abort and IF starvation (with or without MEM_ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic [1:0]    owner;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clock     (clock),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .owner     (owner)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // All sampling and driving happens at the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_owner"}, {30'd0, owner}, 32'd0);
    check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check({tag, "_if_ready"}, {31'd0, if_ready}, 32'd0);
    check({tag, "_dm_ready"}, {31'd0, dm_ready}, 32'd0);
  endtask

  // Called in the ISSUE cycle; returns in the DONE cycle with a memory of latency lat.
  task automatic respond(input int lat, input logic [DW-1:0] data);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check("wait_if_ready", {31'd0, if_ready}, 32'd0);
      check("wait_dm_ready", {31'd0, dm_ready}, 32'd0);
      if (i == lat) begin
        mem_valid = 1'b1;
        mem_rdata = data;
      end
    end
    tick();
    mem_valid = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_quiet("reset");
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_dm_rdata", dm_rdata, 32'd0);

    // IF read, 1-cycle memory: ready 3 cycles after the request is sampled.
    if_req  = 1'b1;
    if_addr = 32'h40;
    tick();
    check("ifrd_mem_en", {31'd0, mem_en}, 32'd1);
    check("ifrd_mem_we", {31'd0, mem_we}, 32'd0);
    check("ifrd_mem_addr", mem_addr, 32'h40);
    check("ifrd_owner", {30'd0, owner}, 32'd1);
    respond(1, 32'h2002_000A);
    check("ifrd_if_ready", {31'd0, if_ready}, 32'd1);
    check("ifrd_dm_ready", {31'd0, dm_ready}, 32'd0);
    check("ifrd_if_rdata", if_rdata, 32'h2002_000A);
    check("ifrd_owner_done", {30'd0, owner}, 32'd1);
    if_req = 1'b0;
    tick();
    check_quiet("ifrd_idle");
    check("ifrd_rdata_held", if_rdata, 32'h2002_000A);

    // DM write, 3-cycle memory.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("dmwr_mem_en", {31'd0, mem_en}, 32'd1);
    check("dmwr_mem_we", {31'd0, mem_we}, 32'd1);
    check("dmwr_mem_addr", mem_addr, 32'h100);
    check("dmwr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("dmwr_owner", {30'd0, owner}, 32'd2);
    respond(3, 32'h1234_5678);
    check("dmwr_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("dmwr_if_ready", {31'd0, if_ready}, 32'd0);
    check("dmwr_dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    check_quiet("dmwr_idle");

    // Simultaneous requests: DM first, then IF.
    if_req  = 1'b1;
    if_addr = 32'h80;
    dm_req  = 1'b1;
    dm_addr = 32'h200;
    tick();
    check("sim_owner_dm", {30'd0, owner}, 32'd2);
    check("sim_mem_addr_dm", mem_addr, 32'h200);
    check("sim_mem_we", {31'd0, mem_we}, 32'd0);
    respond(1, 32'hA5A5_0001);
    check("sim_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("sim_if_ready0", {31'd0, if_ready}, 32'd0);
    check("sim_dm_rdata", dm_rdata, 32'hA5A5_0001);
    dm_req = 1'b0;
    tick();
    check_quiet("sim_idle");
    tick();
    check("sim_owner_if", {30'd0, owner}, 32'd1);
    check("sim_mem_addr_if", mem_addr, 32'h80);
    respond(2, 32'h0BAD_F00D);
    check("sim_if_ready", {31'd0, if_ready}, 32'd1);
    check("sim_dm_ready0", {31'd0, dm_ready}, 32'd0);
    check("sim_if_rdata", if_rdata, 32'h0BAD_F00D);
    check("sim_dm_rdata_held", dm_rdata, 32'hA5A5_0001);
    if_req = 1'b0;
    tick();
    check_quiet("sim_idle2");

    // Stray mem_valid while idle.
    mem_valid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    check_quiet("stray_a");
    mem_valid = 1'b0;
    tick();
    check_quiet("stray_b");
    check("stray_if_rdata", if_rdata, 32'h0BAD_F00D);

    // Reset mid-WAIT, then a late completion.
    if_req  = 1'b1;
    if_addr = 32'h44;
    tick();
    check("rstw_issue", {31'd0, mem_en}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    if_req = 1'b0;
    check_quiet("rstw_after");
    check("rstw_mem_addr", mem_addr, 32'd0);
    check("rstw_if_rdata", if_rdata, 32'd0);
    check("rstw_dm_rdata", dm_rdata, 32'd0);
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_valid = 1'b0;
    check_quiet("rstw_late_a");
    tick();
    check_quiet("rstw_late_b");
    check("rstw_late_if_rdata", if_rdata, 32'd0);

    // Starvation: both requests held through six arbitrations.
    if_req  = 1'b1;
    if_addr = 32'h300;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_owner;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_owner = (k == 4) ? 2'b01 : 2'b10;
`else
      exp_owner = 2'b10;
`endif
      tick();
      check($sformatf("starve_owner_%0d", k), {30'd0, owner}, {30'd0, exp_owner});
      respond(1, 32'hC000_0000 + k);
      check($sformatf("starve_if_ready_%0d", k), {31'd0, if_ready}, {31'd0, exp_owner[0]});
      check($sformatf("starve_dm_ready_%0d", k), {31'd0, dm_ready}, {31'd0, exp_owner[1]});
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    tick();
    check_quiet("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
